// File: rtl/mmio_timer.sv
// mmio_timer -- memory-mapped 32-bit timer with interrupt and free-running tick counter.
//
// Register map (word addresses, addr[1:0] ignored):
//   0x4000_0000  TH       reload value, loaded into TL when TL overflows
//   0x4000_0004  TL       counter, advances on each count tick while enabled
//   0x4000_0008  TCON     [0] enable, [1] irq_en, [2] status (sticky overflow flag)
//   0x4000_000C  PSC      prescale divisor (only with TIMER_PRESCALE_EN, else reads 0)
//   0x4000_0014  SYSTICK  read-only cycle counter, always running
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   mem_read     MEM-stage load strobe
//   mem_write    MEM-stage store strobe
//   addr[31:0]   MEM-stage byte address
//   wdata[31:0]  store data
//   rdata[31:0]  load data (combinational, 0 when not a load hitting this block)
//   kernel_mode  1 while the CPU executes the handler; masks irq
//   irq          interrupt request = irq_en & status & ~kernel_mode
//   sel          addr decodes to a mapped word of this block
//
// Build option: define TIMER_PRESCALE_EN to add a 16-bit prescaler in front of TL.
// Without it, TL advances every clock while enabled and PSC is a read-as-zero word.

module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        kernel_mode,
  output logic        irq,
  output logic        sel
);

  // 0x4000_0000 >> 5: the 32-byte window holding the register file.
  localparam logic [26:0] BASE_HI      = 27'h200_0000;
  // Word indices 0,1,2,3,5 are implemented; 4, 6 and 7 are holes.
  localparam logic [7:0]  MAPPED_WORDS = 8'b0010_1111;

  localparam logic [2:0]  W_TH      = 3'd0;
  localparam logic [2:0]  W_TL      = 3'd1;
  localparam logic [2:0]  W_TCON    = 3'd2;
  localparam logic [2:0]  W_PSC     = 3'd3;
  localparam logic [2:0]  W_SYSTICK = 3'd5;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       base_hit;
  logic [7:0] word_hit;
  logic       unused_addr_bits;

  assign base_hit = (addr[31:5] == BASE_HI);

  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign word_hit[gi] = base_hit && (addr[4:2] == 3'(gi)) && MAPPED_WORDS[gi];
  end

  assign sel = |word_hit;

  // Byte offset within a word carries no meaning for this block.
  assign unused_addr_bits = ^addr[1:0];

  logic wr_th;
  logic wr_tl;
  logic wr_tcon;

  assign wr_th   = mem_write && word_hit[W_TH];
  assign wr_tl   = mem_write && word_hit[W_TL];
  assign wr_tcon = mem_write && word_hit[W_TCON];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] th_q,      th_d;
  logic [31:0] tl_q,      tl_d;
  logic [2:0]  tcon_q,    tcon_d;
  logic [31:0] systick_q, systick_d;
  logic        tick;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc_q,  psc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        wr_psc;

  assign wr_psc = mem_write && word_hit[W_PSC];

  // One tick each time the prescale counter reaches PSC, so the period is PSC+1.
  assign tick = tcon_q[0] && (pcnt_q == psc_q);

  always_comb begin
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    if (wr_psc) begin
      psc_d  = wdata[15:0];
      pcnt_d = 16'd0;  // restart the divide period from the new value
    end else if (tcon_q[0]) begin
      pcnt_d = (pcnt_q == psc_q) ? 16'd0 : pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q  <= 16'd0;
      pcnt_q <= 16'd0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick = tcon_q[0];
`endif

  // ---------------------------------------------------------------------------
  // Counter / reload / status
  // ---------------------------------------------------------------------------
  logic reload_evt;
  logic status_set;

  // A software store to TL wins over the count, suppressing the reload and its flag.
  assign reload_evt = tick && (tl_q == 32'hFFFF_FFFF) && !wr_tl;
  assign status_set = reload_evt && tcon_q[1];

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;

    if (wr_th) begin
      th_d = wdata;
    end

    if (wr_tl) begin
      tl_d = wdata;
    end else if (reload_evt) begin
      tl_d = th_q;
    end else if (tick) begin
      tl_d = tl_q + 32'd1;
    end

    // A TCON store in the same cycle as an overflow still leaves status set,
    // so the overflow can never be silently dropped.
    if (wr_tcon) begin
      tcon_d = {wdata[2] | status_set, wdata[1:0]};
    end else if (status_set) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      systick_q <= 32'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'd0;
    if (mem_read && sel) begin
      case (addr[4:2])
        W_TH:      rdata = th_q;
        W_TL:      rdata = tl_q;
        W_TCON:    rdata = {29'd0, tcon_q};
`ifdef TIMER_PRESCALE_EN
        W_PSC:     rdata = {16'd0, psc_q};
`else
        W_PSC:     rdata = 32'd0;
`endif
        W_SYSTICK: rdata = systick_q;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign irq = tcon_q[1] & tcon_q[2] & ~kernel_mode;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        kernel_mode = 1'b0;
  logic        irq;
  logic        sel;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_PSC  = 32'h4000_000C;
  localparam logic [31:0] A_SYS  = 32'h4000_0014;

  mmio_timer dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .kernel_mode(kernel_mode),
    .irq        (irq),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: register contents described as plain numbers.
  // ---------------------------------------------------------------------------
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [15:0] m_psc;
  int          m_since_tick;  // cycles counted toward the next prescaled tick

  function automatic logic is_mapped(input logic [31:0] a);
    return (a >= 32'h4000_0000) && (a < 32'h4000_0020) &&
           (a[4:2] inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!is_mapped(a)) return 32'd0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_tcon};
`ifdef TIMER_PRESCALE_EN
      3'd3: return {16'd0, m_psc};
`endif
      3'd5: return m_systick;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_psc = 0; m_systick = 0; m_since_tick = 0;
  endtask

  // One clock edge of the timer, applied to the model from the inputs seen at that edge.
  task automatic model_clock();
    logic        wr;
    int          word;
    logic        ticked;
    logic        wrapped;
    logic [31:0] new_tl;
    logic [2:0]  new_tcon;
    wr     = mem_write && is_mapped(addr);
    word   = int'(addr[4:2]);
    ticked = 1'b0;
    if (m_tcon[0]) begin
`ifdef TIMER_PRESCALE_EN
      if (m_since_tick == int'(m_psc)) begin
        ticked = 1'b1;
        m_since_tick = 0;
      end else begin
        m_since_tick = m_since_tick + 1;
      end
`else
      ticked = 1'b1;
`endif
    end
    wrapped  = ticked && (m_tl == 32'hFFFF_FFFF) && !(wr && word == 1);
    new_tl   = (wr && word == 1) ? wdata : wrapped ? m_th : ticked ? m_tl + 1 : m_tl;
    new_tcon = (wr && word == 2) ? wdata[2:0] : m_tcon;
    if (wrapped && m_tcon[1]) new_tcon[2] = 1'b1;
    if (wr && word == 0) m_th = wdata;
`ifdef TIMER_PRESCALE_EN
    if (wr && word == 3) begin
      m_psc = wdata[15:0];
      m_since_tick = 0;
    end
`endif
    m_tl      = new_tl;
    m_tcon    = new_tcon;
    m_systick = m_systick + 1;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_clock();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    $display("store %h <= %h", a, d);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; mem_read = 1'b1;
    #1;
    chk(tag, rdata, exp);
    $display("load  %h -> %h (%s)", a, rdata, tag);
    mem_read = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic [31:0] exp_rd;
    int          r;

    model_reset();
    #2;
    rd("rst_th", A_TH, 32'd0);
    rd("rst_tl", A_TL, 32'd0);
    rd("rst_tcon", A_TCON, 32'd0);
    rd("rst_psc", A_PSC, 32'd0);
    rd("rst_systick", A_SYS, 32'd0);
    chk_irq("rst_irq", 1'b0);
    step();
    reset = 1'b0;

    // Overflow and reload
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    step();
    rd("ovf_tl_max", A_TL, 32'hFFFF_FFFF);
    rd("ovf_tcon_pre", A_TCON, 32'd3);
    step();
    rd("ovf_tl_reload", A_TL, 32'hFFFF_FFFD);
    rd("ovf_tcon_set", A_TCON, 32'd7);
    chk_irq("ovf_irq", 1'b1);

    // Kernel masking and software clear
    kernel_mode = 1'b1;
    chk_irq("kmask_irq0", 1'b0);
    kernel_mode = 1'b0;
    chk_irq("kmask_irq1", 1'b1);
    wr(A_TCON, 32'd3);
    chk_irq("clear_irq", 1'b0);
    rd("clear_tcon", A_TCON, 32'd3);

    // Write/overflow collision: TL store wins, no status
    wr(A_TCON, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TL, 32'h10);
    rd("coll_tl", A_TL, 32'h10);
    rd("coll_tl_tcon", A_TCON, 32'd3);
    // Collision with a TCON store: status still set
    wr(A_TCON, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd3);
    rd("coll_tcon", A_TCON, 32'd7);
    rd("coll_tcon_tl", A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'd0);

    // Read decode
    rd("dec_systick", A_SYS, m_systick);
    rd("dec_hole", 32'h4000_0010, 32'd0);
    chk("dec_hole_sel", {31'd0, sel}, 32'd0);
    rd("dec_far", 32'h1000_0000, 32'd0);
    chk("dec_far_sel", {31'd0, sel}, 32'd0);
    rd("dec_byteoff", 32'h4000_0006, m_tl);
    chk("dec_byteoff_sel", {31'd0, sel}, 32'd1);

    // Prescaler
    wr(A_PSC, 32'd3);
`ifdef TIMER_PRESCALE_EN
    rd("psc_read", A_PSC, 32'd3);
`else
    rd("psc_read", A_PSC, 32'd0);
`endif
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
`ifdef TIMER_PRESCALE_EN
      rd($sformatf("psc_tl%0d", k), A_TL, 32'(k / 4));
`else
      rd($sformatf("psc_tl%0d", k), A_TL, 32'(k));
`endif
    end

    // Reset mid-count
    wr(A_TH, 32'h1234);
    wr(A_TL, 32'd5);
    wr(A_TCON, 32'd3);
    step();
    step();
    reset = 1'b1;
    model_reset();
    rd("mid_th", A_TH, 32'd0);
    rd("mid_tl", A_TL, 32'd0);
    rd("mid_tcon", A_TCON, 32'd0);
    rd("mid_psc", A_PSC, 32'd0);
    rd("mid_systick", A_SYS, 32'd0);
    chk_irq("mid_irq", 1'b0);
    step();
    reset = 1'b0;
    step();
    rd("mid_systick_restart", A_SYS, 32'd1);
    step();
    step();
    rd("mid_tl_idle", A_TL, 32'd0);
    rd("mid_tcon_idle", A_TCON, 32'd0);

    // Randomized traffic against the model
    wr(A_TH, 32'hFFFF_FFF0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r < 8)       a = 32'h4000_0000 | (32'(r) << 2) | 32'($urandom_range(0, 3));
      else if (r < 10) a = A_TCON;
      else             a = $urandom;
      mem_write   = ($urandom_range(0, 2) == 0);
      mem_read    = $urandom_range(0, 1) == 1;
      kernel_mode = ($urandom_range(0, 3) == 0);
      case (a[4:2])
        3'd0, 3'd1: wdata = $urandom_range(0, 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        3'd3:       wdata = 32'($urandom_range(0, 3));
        default:    wdata = $urandom;
      endcase
      addr = a;
      #1;
      exp_rd = mem_read ? model_read(a) : 32'd0;
      chk($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
      chk($sformatf("rnd%0d_sel", i), {31'd0, sel}, {31'd0, is_mapped(a)});
      chk($sformatf("rnd%0d_irq", i), {31'd0, irq},
          {31'd0, m_tcon[1] & m_tcon[2] & ~kernel_mode});
      $display("rnd %0d addr=%h rd=%0b wr=%0b wdata=%h rdata=%h irq=%0b",
               i, a, mem_read, mem_write, wdata, rdata, irq);
      step();
    end
    mem_write = 1'b0;
    mem_read  = 1'b0;
    kernel_mode = 1'b0;
    rd("final_tl", A_TL, m_tl);
    rd("final_tcon", A_TCON, {29'd0, m_tcon});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
